uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters sharing the UART transmit FIFO write port.
REQ-002 Parameter DBIT, default 8, data bits per byte.
REQ-003 Parameter MAX_LEN, default 16, maximum bytes per grant before forced release.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester request; held high while the requester has a byte presented.
REQ-007 din  input  NREQ*DBIT  per-requester byte; requester i occupies bits [i*DBIT +: DBIT].
REQ-008 last  input  NREQ  per-requester flag marking the presented byte as the final byte of a message.
REQ-009 ack  output  NREQ  per-requester one-cycle pulse: presented byte accepted this cycle.
REQ-010 gnt  output  NREQ  one-hot current grant; all-zero when idle.
REQ-011 tx_full  input  1  UART transmit FIFO full.
REQ-012 wr_uart  output  1  UART transmit FIFO write strobe.
REQ-013 w_data  output  DBIT  byte to the UART transmit FIFO.
REQ-014 busy  output  1  high whenever a grant is held.
REQ-015 err  output  1  one-cycle pulse on forced release (abort or length overrun).

Function
REQ-016 The FSM SHALL have two states: IDLE and SEND.
REQ-017 In IDLE with any req high, the arbiter SHALL register a one-hot gnt for the first requester with req high, scanning round-robin from ptr+1 modulo NREQ, and SHALL enter SEND on the next edge.
REQ-018 Grant latency SHALL be exactly one cycle from req rising in IDLE to gnt valid; no byte is accepted in IDLE.
REQ-019 In SEND with granted index g, acceptance SHALL occur when req[g]=1 and tx_full=0.
REQ-020 On acceptance, wr_uart=1, ack[g]=1 and w_data=din[g] SHALL be driven combinationally in the same cycle; otherwise wr_uart=0, ack=0, and w_data=din[g] (0 in IDLE).
REQ-021 While tx_full=1, the arbiter SHALL hold gnt and SHALL NOT pulse wr_uart or ack.
REQ-022 The byte counter cnt SHALL reset to 0 on each new grant and increment on each acceptance; its width is clog2(MAX_LEN)+1.
REQ-023 On acceptance with last[g]=1, the arbiter SHALL return to IDLE, clear gnt, and set ptr=g.
REQ-024 On acceptance with last[g]=0 and cnt=MAX_LEN-1, the arbiter SHALL return to IDLE, set ptr=g and pulse err (overrun).
REQ-025 If req[g]=0 in SEND, the arbiter SHALL return to IDLE, set ptr=g and pulse err (abort); no byte is written.
REQ-026 Requests from non-granted requesters SHALL never receive ack and SHALL NOT preempt the current grant.
REQ-027 Every return to IDLE SHALL spend at least one cycle in IDLE (gnt=0) before the next grant.
REQ-028 With all NREQ requesters continuously requesting, grants SHALL rotate in the order g, g+1, ... modulo NREQ.
REQ-029 busy SHALL equal (state==SEND).

Reset
REQ-030 On reset: state=IDLE, gnt=0, ack=0, wr_uart=0, w_data=0, busy=0, err=0, cnt=0, ptr=NREQ-1, so requester 0 has first priority.
REQ-031 Reset asserted mid-message SHALL abort it on that edge with no wr_uart and no err pulse.

Structure
REQ-032 State encoding and a clog2 function SHALL live in a shared package uart_pkg.
REQ-033 Round-robin selection SHALL be a sub-module rr_pick (inputs req and ptr; output one-hot and index), purely combinational.
REQ-034 The block SHALL connect to the existing uart wr_uart/w_data/tx_full ports with no glue logic.

Verification
REQ-035 Reset release, req=001, din0=0x41, last0=1, tx_full=0 -> gnt=001 at cycle 1; wr_uart and ack0 with w_data=0x41 at cycle 1; gnt=000 at cycle 2.
REQ-036 req=111, every requester sends a 1-byte message, sustained -> grants in order 0,1,2,0; one idle cycle between grants.
REQ-037 Requester 1 sends 3 bytes 0x10,0x11,0x12 (last on 0x12) with tx_full=1 for 2 cycles after the first byte -> exactly 3 wr_uart pulses, bytes in order, no wr_uart while full.
REQ-038 MAX_LEN=4, requester 2 streams with last=0 -> 4 writes, err pulse on the 4th acceptance, then IDLE.
REQ-039 Requester 0 drops req after 1 of 3 bytes -> err pulse, gnt=000 next cycle, requester 1 granted on the following arbitration.
REQ-040 reset asserted during SEND -> all outputs 0 next cycle, no err; next arbitration starts from requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared arbiter state encoding and width helper for the UART TX path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

    // Bits needed to encode n distinct values (0 for n <= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker, scanning from ptr+1 modulo NREQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick_oh,
    output logic [IW-1:0]   pick_idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        w_found  = 1'b0;
        w_j      = 0;
        // ptr < NREQ and k <= NREQ, so a single subtraction wraps the index.
        for (int k = 1; k <= NREQ; k++) begin
            w_j = int'(ptr) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (!w_found && req[w_j]) begin
                pick_oh[w_j] = 1'b1;
                pick_idx     = IW'(w_j);
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one UART TX FIFO write port among NREQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int DBIT    = 8,
    parameter int MAX_LEN = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DBIT-1:0] din,
    input  logic [NREQ-1:0]      last,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      gnt,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [DBIT-1:0]      w_data,
    output logic                 busy,
    output logic                 err
);

    localparam int c_IW = (NREQ > 1) ? clog2(NREQ) : 1;
    localparam int c_CW = clog2(MAX_LEN) + 1;
    localparam logic [c_IW-1:0] c_PTR_RST  = c_IW'(NREQ - 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(MAX_LEN - 1);

    arb_state_t      r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt,   w_gnt_nxt;
    logic [c_IW-1:0] r_gidx,  w_gidx_nxt;
    logic [c_IW-1:0] r_ptr,   w_ptr_nxt;
    logic [c_CW-1:0] r_cnt,   w_cnt_nxt;

    logic [NREQ-1:0] w_pick_oh;
    logic [c_IW-1:0] w_pick_idx;
    logic [DBIT-1:0] w_din_g;
    logic            w_send, w_accept, w_abort, w_overrun, w_release;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (c_IW)
    ) u_rr_pick (
        .req      (req),
        .ptr      (r_ptr),
        .pick_oh  (w_pick_oh),
        .pick_idx (w_pick_idx)
    );

    // Reset gates the combinational strobes so a reset edge aborts silently.
    assign w_send    = (r_state == SEND) && !reset;
    assign w_din_g   = din[int'(r_gidx)*DBIT +: DBIT];
    assign w_accept  = w_send && req[r_gidx] && !tx_full;
    assign w_abort   = w_send && !req[r_gidx];
    assign w_overrun = w_accept && !last[r_gidx] && (r_cnt == c_CNT_LAST);
    assign w_release = w_abort || (w_accept && (last[r_gidx] || w_overrun));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        wr_uart     = w_accept;
        ack         = w_accept ? r_gnt : '0;
        w_data      = w_send ? w_din_g : '0;
        err         = w_abort || w_overrun;
        gnt         = r_gnt;
        busy        = (r_state == SEND);

        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = SEND;
                    w_gnt_nxt   = w_pick_oh;
                    w_gidx_nxt  = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            SEND: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = r_gidx;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_ptr   <= c_PTR_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter (NREQ=3, DBIT=8, MAX_LEN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ    = 3;
    localparam int DBIT    = 8;
    localparam int MAX_LEN = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] din;
    logic [NREQ-1:0]      last;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      gnt;
    logic                 tx_full;
    logic                 wr_uart;
    logic [DBIT-1:0]      w_data;
    logic                 busy;
    logic                 err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    logic [7:0] wr_log[$];

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .DBIT    (DBIT),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .din     (din),
        .last    (last),
        .ack     (ack),
        .gnt     (gnt),
        .tx_full (tx_full),
        .wr_uart (wr_uart),
        .w_data  (w_data),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Log every write strobe mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (wr_uart) begin
            n_wr = n_wr + 1;
            wr_log.push_back(w_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string t, input logic [2:0] eg, input logic [2:0] ea,
                           input logic ew, input logic [7:0] ed, input logic eb, input logic ee);
        chk({t, ".gnt"},  32'(gnt),     32'(eg));
        chk({t, ".ack"},  32'(ack),     32'(ea));
        chk({t, ".wr"},   32'(wr_uart), 32'(ew));
        chk({t, ".data"}, 32'(w_data),  32'(ed));
        chk({t, ".busy"}, 32'(busy),    32'(eb));
        chk({t, ".err"},  32'(err),     32'(ee));
    endtask

    initial begin
        int         nw0;
        logic [2:0] eg;
        logic [7:0] ed;

        reset = 1'b1; req = '0; din = '0; last = '0; tx_full = 1'b0;
        cyc(); cyc(); settle();
        chk_all("reset", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);

        // Single one-byte message from requester 0 right after reset.
        cyc(); reset = 1'b0; req = 3'b001; din = {8'h32, 8'h31, 8'h41}; last = 3'b001; settle();
        chk_all("a_c0", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(); settle();
        chk_all("a_c1", 3'b001, 3'b001, 1'b1, 8'h41, 1'b1, 1'b0);
        cyc(); req = '0; last = '0; settle();
        chk_all("a_c2", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);

        // Sustained 1-byte requests from all three: grants rotate 0,1,2,0 with idle gaps.
        cyc(); reset = 1'b1; settle();
        cyc(); reset = 1'b0; req = 3'b111; last = 3'b111; din = {8'hC2, 8'hC1, 8'hC0}; settle();
        chk_all("b_k0", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            cyc(); settle();
            if (k % 2 == 1) begin
                eg = 3'b001 << ((k / 2) % 3);
                ed = 8'hC0 + 8'((k / 2) % 3);
                chk_all($sformatf("b_k%0d", k), eg, eg, 1'b1, ed, 1'b1, 1'b0);
            end else begin
                chk_all($sformatf("b_k%0d", k), 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
            end
        end
        cyc(); req = '0; last = '0; settle();
        chk_all("b_end", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);

        // Requester 1 sends 3 bytes with back-pressure; requester 0 must not preempt.
        cyc(); req = 3'b011; last = '0; din = {8'h00, 8'h10, 8'hE0}; settle();
        nw0 = n_wr;
        chk_all("c_c0", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(); settle();
        chk_all("c_c1", 3'b010, 3'b010, 1'b1, 8'h10, 1'b1, 1'b0);
        cyc(); tx_full = 1'b1; din[15:8] = 8'h11; settle();
        chk_all("c_c2", 3'b010, 3'b000, 1'b0, 8'h11, 1'b1, 1'b0);
        cyc(); settle();
        chk_all("c_c3", 3'b010, 3'b000, 1'b0, 8'h11, 1'b1, 1'b0);
        cyc(); tx_full = 1'b0; settle();
        chk_all("c_c4", 3'b010, 3'b010, 1'b1, 8'h11, 1'b1, 1'b0);
        cyc(); din[15:8] = 8'h12; last = 3'b010; settle();
        chk_all("c_c5", 3'b010, 3'b010, 1'b1, 8'h12, 1'b1, 1'b0);
        cyc(); req = '0; last = '0; settle();
        chk_all("c_c6", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("c_nwr", 32'(n_wr - nw0), 32'd3);
        if (n_wr - nw0 == 3) begin
            chk("c_byte0", 32'(wr_log[nw0]),     32'h10);
            chk("c_byte1", 32'(wr_log[nw0 + 1]), 32'h11);
            chk("c_byte2", 32'(wr_log[nw0 + 2]), 32'h12);
        end

        // Requester 2 streams without last: overrun on the 4th acceptance.
        cyc(); req = 3'b100; last = '0; din = {8'h20, 16'h0000}; settle();
        chk_all("d_c0", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc(); din[23:16] = 8'h1F + 8'(k); settle();
            chk_all($sformatf("d_c%0d", k), 3'b100, 3'b100, 1'b1, 8'h1F + 8'(k), 1'b1, (k == 4));
        end
        cyc(); req = '0; settle();
        chk_all("d_c5", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);

        // Requester 0 aborts after one byte; requester 1 is next.
        cyc(); req = 3'b011; last = '0; din = {8'h00, 8'h51, 8'h50}; settle();
        chk_all("e_c0", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(); settle();
        chk_all("e_c1", 3'b001, 3'b001, 1'b1, 8'h50, 1'b1, 1'b0);
        cyc(); req = 3'b010; settle();
        chk_all("e_c2", 3'b001, 3'b000, 1'b0, 8'h50, 1'b1, 1'b1);
        cyc(); settle();
        chk_all("e_c3", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(); last = 3'b010; settle();
        chk_all("e_c4", 3'b010, 3'b010, 1'b1, 8'h51, 1'b1, 1'b0);
        cyc(); req = '0; last = '0; settle();
        chk_all("e_c5", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset in the middle of a message from requester 2.
        cyc(); req = 3'b100; din = {8'h70, 16'h0000}; settle();
        chk_all("f_c0", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(); settle();
        chk_all("f_c1", 3'b100, 3'b100, 1'b1, 8'h70, 1'b1, 1'b0);
        cyc(); reset = 1'b1; settle();
        chk("f_rst.wr",  32'(wr_uart), 32'd0);
        chk("f_rst.ack", 32'(ack),     32'd0);
        chk("f_rst.err", 32'(err),     32'd0);
        cyc(); reset = 1'b0; req = 3'b111; last = 3'b111; din = {8'h92, 8'h91, 8'h90}; settle();
        chk_all("f_c3", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(); settle();
        chk_all("f_c4", 3'b001, 3'b001, 1'b1, 8'h90, 1'b1, 1'b0);
        cyc(); req = '0; last = '0; settle();
        chk_all("f_c5", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
